// File: rtl/mseq_pkg.sv
// ----------------------------------------------------------------------------
// mseq_pkg
// Shared constants and types for the mseq_gen LFSR burst generator.
//   MSEQ_W       : width of the shift register, seed and tap mask
//   mseq_state_e : burst controller states
// ----------------------------------------------------------------------------
package mseq_pkg;

    localparam int unsigned MSEQ_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mseq_state_e;

endpackage : mseq_pkg

// File: rtl/mseq_gen_mfun.sv
// ----------------------------------------------------------------------------
// mfun
// Combinational Fibonacci LFSR step.
//   fase     : current register state
//   type_f   : feedback tap mask (bit i set = state bit i joins the XOR)
//   o_sum_c  : feedback bit, which is also the bit emitted for this state
//   o_next_c : next state, feedback shifted in at the MSB
// ----------------------------------------------------------------------------
module mfun
    import mseq_pkg::*;
(
    input  logic [MSEQ_W-1:0] fase,
    input  logic [MSEQ_W-1:0] type_f,
    output logic              o_sum_c,
    output logic [MSEQ_W-1:0] o_next_c
);

    assign o_sum_c  = ^(fase & type_f);
    assign o_next_c = {o_sum_c, fase[MSEQ_W-1:1]};

endmodule : mfun

// File: rtl/mseq_gen.sv
// ----------------------------------------------------------------------------
// mseq_gen
// Emits bursts of LFSR sequence bits over a valid/ready handshake.
//   clk, rst_n      : clock, asynchronous active-low reset
//   load,seed,taps  : capture seed and tap mask while idle
//   start,len       : begin a burst of len bits while idle
//   abort           : drop the running burst (no done pulse)
//   bit_out         : current sequence bit (combinational from registers)
//   bit_valid       : bit_out valid; bit_ready accepts it
//   busy, done      : burst in progress / one-cycle completion pulse
//   period_wrap     : pulse after a step that lands back on the seed
//   err_zero        : sticky all-zero-state error
//   state_out       : current shift register contents
// ----------------------------------------------------------------------------
module mseq_gen
    import mseq_pkg::*;
#(
    parameter int unsigned LEN_W = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [MSEQ_W-1:0] seed,
    input  logic [MSEQ_W-1:0] taps,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              bit_out,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              busy,
    output logic              done,
    output logic              period_wrap,
    output logic              err_zero,
    output logic [MSEQ_W-1:0] state_out
);

    mseq_state_e       r_fsm;
    mseq_state_e       w_fsm_nxt;
    logic [MSEQ_W-1:0] r_state;
    logic [MSEQ_W-1:0] r_seed;
    logic [MSEQ_W-1:0] r_taps;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_err_zero;
    logic              r_bit_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_period_wrap;

    logic [MSEQ_W-1:0] w_state_nxt;
    logic [MSEQ_W-1:0] w_seed_nxt;
    logic [MSEQ_W-1:0] w_taps_nxt;
    logic [LEN_W-1:0]  w_cnt_nxt;
    logic              w_err_nxt;
    logic              w_wrap_nxt;
    logic              w_sum;
    logic [MSEQ_W-1:0] w_next;

    // LFSR step of the current state
    mfun u_mfun (
        .fase     (r_state),
        .type_f   (r_taps),
        .o_sum_c  (w_sum),
        .o_next_c (w_next)
    );

    // Next-state and datapath update
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_seed_nxt  = r_seed;
        w_taps_nxt  = r_taps;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err_zero;
        w_wrap_nxt  = 1'b0;

        case (r_fsm)
            ST_IDLE: begin
                if (load) begin
                    w_state_nxt = seed;
                    w_seed_nxt  = seed;
                    w_taps_nxt  = taps;
                    w_err_nxt   = (seed == '0);
                end else if (start) begin
                    // A zero state would lock the LFSR; refuse the burst
                    if (r_state == '0) begin
                        w_err_nxt = 1'b1;
                    end else if (len == '0) begin
                        w_fsm_nxt = ST_DONE;
                    end else begin
                        w_cnt_nxt = len;
                        w_fsm_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // Abort wins over a simultaneous handshake
                if (abort) begin
                    w_fsm_nxt = ST_IDLE;
                end else if (bit_ready) begin
                    w_state_nxt = w_next;
                    w_cnt_nxt   = r_cnt - LEN_W'(1);
                    w_wrap_nxt  = (w_next == r_seed);
                    if (r_cnt == LEN_W'(1)) begin
                        w_fsm_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_fsm_nxt = ST_IDLE;
            end
            default: begin
                w_fsm_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm         <= ST_IDLE;
            r_state       <= '0;
            r_seed        <= '0;
            r_taps        <= '0;
            r_cnt         <= '0;
            r_err_zero    <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_period_wrap <= 1'b0;
        end else begin
            r_fsm         <= w_fsm_nxt;
            r_state       <= w_state_nxt;
            r_seed        <= w_seed_nxt;
            r_taps        <= w_taps_nxt;
            r_cnt         <= w_cnt_nxt;
            r_err_zero    <= w_err_nxt;
            r_bit_valid   <= (w_fsm_nxt == ST_RUN);
            r_busy        <= (w_fsm_nxt == ST_RUN);
            r_done        <= (w_fsm_nxt == ST_DONE);
            r_period_wrap <= w_wrap_nxt;
        end
    end

    assign bit_out     = w_sum;
    assign bit_valid   = r_bit_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign period_wrap = r_period_wrap;
    assign err_zero    = r_err_zero;
    assign state_out   = r_state;

endmodule : mseq_gen

// File: doc/mseq_gen.md
MSEQ_GEN -- requirements
Module: mseq_gen

Interface
REQ-001 Parameter: LEN_W, default 8, width of the burst-length input and internal bit counter.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: load  input  1  capture seed and taps (IDLE only).
REQ-005 Port: seed  input  5  initial register state.
REQ-006 Port: taps  input  5  feedback mask; bit i set = state bit i in the XOR.
REQ-007 Port: start  input  1  begin burst of len bits (IDLE only).
REQ-008 Port: len  input  LEN_W  number of bits to emit, sampled on accepted start.
REQ-009 Port: abort  input  1  terminate burst.
REQ-010 Port: bit_out  output  1  current sequence bit.
REQ-011 Port: bit_valid  output  1  bit_out valid.
REQ-012 Port: bit_ready  input  1  consumer accepts bit.
REQ-013 Port: busy  output  1  high in RUN.
REQ-014 Port: done  output  1  one-cycle pulse at burst completion.
REQ-015 Port: period_wrap  output  1  one-cycle pulse when the stepped state equals stored seed.
REQ-016 Port: err_zero  output  1  sticky all-zero-state error.
REQ-017 Port: state_out  output  5  current state register.

Function
REQ-018 Registers: state_reg[4:0], seed_reg[4:0], taps_reg[4:0], cnt[LEN_W-1:0], FSM IDLE/RUN/DONE.
REQ-019 Step: sum = XOR over i of (state_reg[i] & taps_reg[i]); next = {sum, state_reg[4:1]}.
REQ-020 bit_out = sum of current state_reg, combinational from registers; stable while bit_valid & !bit_ready.
REQ-021 IDLE, load=1: state_reg, seed_reg <= seed; taps_reg <= taps; err_zero <= (seed == 0).
REQ-022 IDLE, load and start same cycle: load executes, start ignored.
REQ-023 IDLE, start=1, load=0, state_reg != 0, len != 0: cnt <= len, -> RUN next cycle.
REQ-024 IDLE, start=1, len == 0: no bits emitted, -> DONE next cycle.
REQ-025 IDLE, start=1, state_reg == 0: err_zero <= 1, remain IDLE, no done.
REQ-026 RUN: bit_valid=1, busy=1; load and start ignored.
REQ-027 RUN, bit_valid & bit_ready: state_reg <= next, cnt <= cnt-1; if cnt == 1 -> DONE.
REQ-028 RUN, bit_valid & !bit_ready: state_reg, cnt hold.
REQ-029 period_wrap=1 in the cycle following an accepted handshake whose next equals seed_reg.
REQ-030 RUN, abort=1: -> IDLE next cycle, takes priority over handshake; state_reg keeps last value, no done pulse, no step.
REQ-031 DONE: done=1, bit_valid=0, busy=0 for exactly one cycle, -> IDLE.
REQ-032 State persists across bursts; a new start continues the sequence without reload.
REQ-033 err_zero cleared only by load with nonzero seed.
REQ-034 Latency: first bit valid the cycle after accepted start; one bit per cycle with bit_ready held high.

Reset
REQ-035 rst_n low: FSM IDLE; state_reg, seed_reg, taps_reg, cnt = 0; bit_valid, busy, done, period_wrap, err_zero = 0, immediately and asynchronously.
REQ-036 Reset mid-burst discards the burst with no done pulse; a load is required before the next start.

Structure
REQ-037 Package mseq_pkg holds the FSM state enum and constant MSEQ_W = 5.
REQ-038 Combinational step is one instance of the existing mfun sub-module (fase = state_reg, type_f = taps_reg).

Verification
REQ-039 load seed=5'b00001, taps=5'b00101; start len=4, bit_ready=1 -> bits 1,0,0,1, states 10000,01000,00100,10010, done one cycle after 4th bit.
REQ-040 Same config, len=31 -> period_wrap pulses once, after the 31st bit, state_out=00001.
REQ-041 bit_ready low 3 cycles mid-burst -> bit_out, state_out frozen, no bit lost or duplicated.
REQ-042 load seed=0, then start -> err_zero=1, busy never asserts; load seed=5'b00011 clears err_zero.
REQ-043 abort after 2 bits of a len=10 burst -> IDLE next cycle, no done, state_out holds 2-step state.
REQ-044 rst_n asserted mid-burst -> all outputs 0 asynchronously; start len=0 after load -> done one cycle later, no bit_valid.
